mul_div_seq: RTL and testbench

- Parametrised iterative multiply/divide unit; successor to the fixed 8-bit combinational mul/div.
- One shared datapath performs a WIDTH-cycle shift-add multiply or restoring divide.
- Returns the full 2*WIDTH product, or quotient and remainder, plus a divide-by-zero flag.
- Sits behind the ALU op decoder; a start/busy/done handshake lets the ALU stall on long ops.

---
 rtl/mul_div_pkg.sv | 13 +
 rtl/muldiv_sign_fix.sv | 60 ++++++
 rtl/mul_div_seq.sv | 177 +++++++++++++++++
 tb/tb_mul_div_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared op encodings and FSM state type for the iterative mul/div unit.
package mul_div_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational magnitude extraction at accept and sign restore at DONE entry.
// Only instantiated when MULDIV_SIGNED_EN is defined.
module muldiv_sign_fix
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             sgn,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             neg_lo,
    output logic             neg_hi,
    input  logic             fix_op,
    input  logic             fix_neg_lo,
    input  logic             fix_neg_hi,
    input  logic [WIDTH-1:0] raw_lo,
    input  logic [WIDTH-1:0] raw_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi
);

    logic               a_neg;
    logic               b_neg;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_n;

    always_comb begin
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
        // A zero divisor keeps the all-ones quotient and lets |a| map back to a.
        if (op == OP_MUL) begin
            neg_lo = a_neg ^ b_neg;
            neg_hi = a_neg ^ b_neg;
        end else begin
            neg_lo = (a_neg ^ b_neg) & (b != '0);
            neg_hi = a_neg;
        end
    end

    always_comb begin
        prod   = {raw_hi, raw_lo};
        prod_n = ~prod + 1'b1;
        out_lo = raw_lo;
        out_hi = raw_hi;
        if (fix_op == OP_MUL) begin
            if (fix_neg_lo) begin
                {out_hi, out_lo} = prod_n;
            end
        end else begin
            if (fix_neg_lo) out_lo = ~raw_lo + 1'b1;
            if (fix_neg_hi) out_hi = ~raw_hi + 1'b1;
        end
    end

endmodule

// File: rtl/mul_div_seq.sv
// Iterative shift-add multiply / restoring divide with start/busy/done handshake.
// Optional two's-complement mode is enabled by defining MULDIV_SIGNED_EN.
module mul_div_seq
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
`ifdef MULDIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_lo, neg_hi;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH:0]   it_hi;
    logic [WIDTH-1:0] it_lo;
    logic [WIDTH-1:0] fix_lo, fix_hi;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] diff;
    logic             ge;

`ifdef MULDIV_SIGNED_EN
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .sgn        (signed_op),
        .op         (op),
        .a          (a),
        .b          (b),
        .a_mag      (a_mag),
        .b_mag      (b_mag),
        .neg_lo     (neg_lo),
        .neg_hi     (neg_hi),
        .fix_op     (op_q),
        .fix_neg_lo (neg_lo_q),
        .fix_neg_hi (neg_hi_q),
        .raw_lo     (it_lo),
        .raw_hi     (it_hi[WIDTH-1:0]),
        .out_lo     (fix_lo),
        .out_hi     (fix_hi)
    );
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign neg_lo = 1'b0;
    assign neg_hi = 1'b0;
    assign fix_lo = it_lo;
    assign fix_hi = it_hi[WIDTH-1:0];
`endif

    // Remainder MSB is always clear once a step settles; kept for the trial subtract.
    logic unused_bits;
    assign unused_bits = ^{hi_q[WIDTH], it_hi[WIDTH], neg_lo_q, neg_hi_q};

    always_comb begin
        sum  = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        sh   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        diff = {1'b0, sh} - {2'b0, opnd_q};
        ge   = ~diff[WIDTH+1];
        if (op_q == OP_MUL) begin
            it_hi = {1'b0, sum[WIDTH:1]};
            it_lo = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
            it_hi = ge ? diff[WIDTH:0] : sh;
            it_lo = {lo_q[WIDTH-2:0], ge};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        accept   = start && (state_q != S_RUN);

        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_RUN;
            end
            S_RUN: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    res_d    = fix_lo;
                    res_hi_d = fix_hi;
                    dbz_d    = (op_q == OP_DIV) && (opnd_q == '0);
                end
            end
            S_DONE: begin
                state_d = accept ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            op_d     = op;
            cnt_d    = '0;
            hi_d     = '0;
            opnd_d   = (op == OP_MUL) ? a_mag : b_mag;
            lo_d     = (op == OP_MUL) ? b_mag : a_mag;
            neg_lo_d = neg_lo;
            neg_hi_d = neg_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign result      = res_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq: random and directed ops against an arithmetic model.
module tb_mul_div_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         sop = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_run = 0;

    mul_div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
`ifdef MULDIV_SIGNED_EN
        .signed_op   (sop),
`endif
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic o, input logic s,
                                  input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic dz);
        int sx, sy, p, q, r;
        dz = 1'b0;
        sx = s ? int'($signed(x)) : int'(x);
        sy = s ? int'($signed(y)) : int'(y);
        if (o == 1'b0) begin
            p  = sx * sy;
            lo = p[7:0];
            hi = p[15:8];
        end else if (y == '0) begin
            lo = '1;
            hi = x;
            dz = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            lo = q[7:0];
            hi = r[7:0];
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                chk("busy_cycles", busy_run, W);
                busy_run = 0;
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL spurious_done: got done=1 at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.due);
                    chk("result", result, e.lo);
                    chk("result_hi", result_hi, e.hi);
                    chk("div_by_zero", div_by_zero, e.dz);
                end
            end
        end
    end

    task automatic issue(input logic o, input logic s,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            start = 1'($urandom_range(0, 1));
            op    = 1'($urandom_range(0, 1));
            a     = W'($urandom);
            b     = W'($urandom);
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            fails++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", n);
        end
        start = 1'b1;
        op    = o;
        sop   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        model(o, s, x, y, e.lo, e.hi, e.dz);
        e.due = cyc + W;
        sb.push_back(e);
        start = 1'b0;
    endtask

    task automatic idle(input int cycles);
        int n;
        n = 0;
        start = 1'b0;
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (cycles) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_hi"}, result_hi, 0);
        chk({tag, "_dbz"}, div_by_zero, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        logic         ro, rs;
        logic [W-1:0] rx, ry;
        int           n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        issue(1'b0, 1'b0, 8'd13, 8'd11);
        idle(2);
        issue(1'b0, 1'b0, 8'hFF, 8'hFF);
        issue(1'b1, 1'b0, 8'd200, 8'd7);
        idle(1);
        issue(1'b1, 1'b0, 8'd5, 8'd0);
        issue(1'b0, 1'b0, 8'd6, 8'd7);
        issue(1'b1, 1'b0, 8'd0, 8'd9);
        issue(1'b1, 1'b0, 8'd3, 8'd250);
        idle(2);

        issue(1'b0, 1'b0, 8'd3, 8'd4);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a = 8'd9;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("abort");
        issue(1'b0, 1'b0, 8'd3, 8'd4);

`ifdef MULDIV_SIGNED_EN
        issue(1'b0, 1'b1, 8'hF9, 8'd3);
        issue(1'b1, 1'b1, 8'hF9, 8'd2);
        issue(1'b1, 1'b1, 8'h80, 8'hFF);
        issue(1'b1, 1'b1, 8'h85, 8'h00);
        issue(1'b0, 1'b1, 8'h80, 8'h80);
        issue(1'b1, 1'b1, 8'd7, 8'hFE);
`endif

        for (int i = 0; i < 200; i++) begin
            ro = 1'($urandom_range(0, 1));
`ifdef MULDIV_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            rx = W'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 5) == 0) rx = 8'h80;
            if ($urandom_range(0, 5) == 0) ry = 8'hFF;
            issue(ro, rs, rx, ry);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
